// File: rtl/vending_machine_multi.sv
// vending_machine_multi: multi-item vending controller with a programmable price
// table, per-item stock counters, cancel/refund and serial nickel change return.
// Ports:
//   clock, reset                      - rising-edge clock, synchronous active-high reset
//   nickel_in/dime_in/quarter_in      - one-cycle coin pulses (1/2/5 nickel units)
//   item_number                       - item index for select, restock and prog_en
//   select, cancel, restock, prog_en  - request pulses; prog_price is the new price
//   dispense, item_out                - vend pulse and the vended item
//   nickel_out                        - one pulse per nickel of change
//   coin_reject, sold_out, insufficient - one-cycle status pulses
//   busy, credit                      - returning change / current credit (nickels)
module vending_machine_multi #(
  parameter int unsigned NUM_ITEMS     = 16,
  parameter int unsigned CREDIT_W      = 6,
  parameter int unsigned PRICE_W       = 5,
  parameter int unsigned STOCK_W       = 4,
  parameter int unsigned DEFAULT_PRICE = 3,
  parameter int unsigned INIT_STOCK    = 2,
  // Derived from NUM_ITEMS; not meant to be overridden.
  parameter int unsigned ITEM_W        = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                nickel_in,
  input  logic                dime_in,
  input  logic                quarter_in,
  input  logic [ITEM_W-1:0]   item_number,
  input  logic                select,
  input  logic                cancel,
  input  logic                restock,
  input  logic                prog_en,
  input  logic [PRICE_W-1:0]  prog_price,
  output logic                dispense,
  output logic [ITEM_W-1:0]   item_out,
  output logic                nickel_out,
  output logic                coin_reject,
  output logic                sold_out,
  output logic                insufficient,
  output logic                busy,
  output logic [CREDIT_W-1:0] credit
);

  localparam int unsigned MASK_W = 2 ** ITEM_W;

  typedef enum logic {S_IDLE, S_CHANGE} state_t;

  // Marks which encodable item indices are real items.
  function automatic logic [MASK_W-1:0] item_mask_f();
    logic [MASK_W-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < NUM_ITEMS; i++) m[i] = 1'b1;
    return m;
  endfunction

  localparam logic [MASK_W-1:0] ITEM_MASK = item_mask_f();

  state_t               state_q, state_d;
  logic [CREDIT_W-1:0]  credit_q, credit_d;
  logic [PRICE_W-1:0]   price_q [NUM_ITEMS];
  logic [PRICE_W-1:0]   price_d [NUM_ITEMS];
  logic [STOCK_W-1:0]   stock_q [NUM_ITEMS];
  logic [STOCK_W-1:0]   stock_d [NUM_ITEMS];
  logic                 dispense_q, dispense_d;
  logic [ITEM_W-1:0]    item_q, item_d;
  logic                 nickel_q, nickel_d;
  logic                 reject_q, reject_d;
  logic                 sold_q, sold_d;
  logic                 insuf_q, insuf_d;
  logic                 busy_q, busy_d;

  logic                 item_ok;
  logic                 coin_any;
  logic                 coin_multi;
  logic [1:0]           coin_cnt;
  logic [CREDIT_W-1:0]  coin_val;
  logic [CREDIT_W:0]    coin_sum;
  logic [CREDIT_W-1:0]  price_sel;
  logic                 sel_ok;

  // Coin decode; coin_val is only meaningful when exactly one coin is present.
  always_comb begin
    coin_cnt   = 2'(nickel_in) + 2'(dime_in) + 2'(quarter_in);
    coin_any   = (coin_cnt != 2'd0);
    coin_multi = (coin_cnt > 2'd1);
    if (quarter_in)   coin_val = CREDIT_W'(5);
    else if (dime_in) coin_val = CREDIT_W'(2);
    else              coin_val = CREDIT_W'(nickel_in);
    coin_sum  = (CREDIT_W+1)'(credit_q) + (CREDIT_W+1)'(coin_val);
    item_ok   = ITEM_MASK[item_number];
    price_sel = CREDIT_W'(price_q[item_number]);
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    credit_d   = credit_q;
    price_d    = price_q;
    stock_d    = stock_q;
    dispense_d = 1'b0;
    item_d     = item_q;
    nickel_d   = 1'b0;
    reject_d   = 1'b0;
    sold_d     = 1'b0;
    insuf_d    = 1'b0;
    sel_ok     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (cancel) begin
          // First refund nickel goes out on the cancel edge itself.
          if (credit_q != '0) begin
            nickel_d = 1'b1;
            credit_d = credit_q - CREDIT_W'(1);
            state_d  = (credit_q > CREDIT_W'(1)) ? S_CHANGE : S_IDLE;
          end
        end else if (select) begin
          if (!item_ok) begin
            insuf_d = 1'b1;
          end else if (stock_q[item_number] == '0) begin
            sold_d = 1'b1;
          end else if (credit_q < price_sel) begin
            insuf_d = 1'b1;
          end else begin
            sel_ok     = 1'b1;
            dispense_d = 1'b1;
            item_d     = item_number;
            credit_d   = credit_q - price_sel;
            stock_d[item_number] = stock_q[item_number] - STOCK_W'(1);
            if (credit_q != price_sel) state_d = S_CHANGE;
          end
        end else if (restock) begin
          if (item_ok) stock_d[item_number] = STOCK_W'(INIT_STOCK);
        end else if (prog_en) begin
          if (item_ok) price_d[item_number] = prog_price;
        end

        // Failed selects still leave credit_d == credit_q, so coins add on top.
        if (coin_any) begin
          if (cancel || sel_ok || coin_multi || coin_sum[CREDIT_W]) reject_d = 1'b1;
          else credit_d = coin_sum[CREDIT_W-1:0];
        end
      end

      S_CHANGE: begin
        nickel_d = 1'b1;
        if (credit_q != '0) credit_d = credit_q - CREDIT_W'(1);
        if (credit_q <= CREDIT_W'(1)) state_d = S_IDLE;
        if (coin_any) reject_d = 1'b1;
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      credit_q   <= '0;
      dispense_q <= 1'b0;
      item_q     <= '0;
      nickel_q   <= 1'b0;
      reject_q   <= 1'b0;
      sold_q     <= 1'b0;
      insuf_q    <= 1'b0;
      busy_q     <= 1'b0;
      for (int i = 0; i < int'(NUM_ITEMS); i++) begin
        price_q[i] <= PRICE_W'(DEFAULT_PRICE);
        stock_q[i] <= STOCK_W'(INIT_STOCK);
      end
    end else begin
      state_q    <= state_d;
      credit_q   <= credit_d;
      price_q    <= price_d;
      stock_q    <= stock_d;
      dispense_q <= dispense_d;
      item_q     <= item_d;
      nickel_q   <= nickel_d;
      reject_q   <= reject_d;
      sold_q     <= sold_d;
      insuf_q    <= insuf_d;
      busy_q     <= busy_d;
    end
  end

  assign dispense     = dispense_q;
  assign item_out     = item_q;
  assign nickel_out   = nickel_q;
  assign coin_reject  = reject_q;
  assign sold_out     = sold_q;
  assign insufficient = insuf_q;
  assign busy         = busy_q;
  assign credit       = credit_q;

endmodule
